// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//
// Shared definitions for the register-file write-port arbiter.
//
//   W_DEF / D_DEF / N_DEF : default data width, address width, requester count
//   addr_t / data_t       : register-file address and data types at the
//                           default widths
//   DROP_CNT_MAX          : saturation value of the address-0 drop counter
//   sat_inc8()            : 8-bit increment that sticks at DROP_CNT_MAX
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int W_DEF = 8;
    localparam int D_DEF = 3;
    localparam int N_DEF = 2;

    typedef logic [D_DEF-1:0] addr_t;
    typedef logic [W_DEF-1:0] data_t;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    // Saturating increment: once the counter reaches DROP_CNT_MAX it holds.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == DROP_CNT_MAX) begin
            return v;
        end
        return v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Starting at ptr_i and moving upward with
// wrap-around, the first set bit of valid_i is granted. The grant vector is
// one-hot, or all zero when nothing is valid, and a grant bit is never set
// without its valid bit.
//
// Ports
//   valid_i : N-bit request vector
//   ptr_i   : priority pointer, must be < N
//   grant_o : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_pick
    import rf_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o
);

    logic [N-1:0] rot;
    logic [N-1:0] g_rot;
    logic         found;

    // Rotate the request vector so that requester ptr_i lands in bit 0.
    // Shifting the doubled vector right by ptr_i and keeping the low N bits
    // performs the wrap without any variable indexing.
    assign rot = N'({valid_i, valid_i} >> ptr_i);

    // Fixed-priority pick on the rotated vector: lowest set bit wins.
    always_comb begin
        g_rot = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                g_rot[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Rotate the one-hot result back: shift the doubled vector left by ptr_i
    // and keep the upper half.
    assign grant_o = N'(({g_rot, g_rot} << ptr_i) >> N);

endmodule

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
//
// Shares the register file's single write port between N requesters using
// round-robin arbitration with an optional per-requester lock. One winner
// per cycle is registered into a write stage that drives the register file.
//
// Handshake: a requester raises req_valid[i] and holds req_addr/req_data
// stable until it sees req_ready[i]; a transfer happens in the cycle where
// both req_valid[i] and req_ready[i] are high. req_ready is combinational
// from req_valid and the priority pointer, is one-hot or zero, and is never
// high without its req_valid. The register file always accepts, so the only
// back-pressure is losing arbitration.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester write request
//   req_addr     : per-requester destination address (N x D, requester 0 in LSBs)
//   req_data     : per-requester write data          (N x W, requester 0 in LSBs)
//   req_lock     : keep priority with this requester after its transfer
//   req_ready    : accept strobe for the current cycle
//   write_en     : register-file write enable (never for address 0)
//   waddr        : register-file write address
//   data_in      : register-file write data
//   pend_valid   : write in flight this cycle (same as write_en)
//   pend_addr    : address of the in-flight write, for read-side RAW detection
//   drop_cnt     : saturating count of accepted address-0 writes
//   dbg_ptr      : current priority pointer, for observation
// -----------------------------------------------------------------------------
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int D = D_DEF,
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*D-1:0]       req_addr,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_lock,
    output logic [N-1:0]         req_ready,
    output logic                 write_en,
    output logic [D-1:0]         waddr,
    output logic [W-1:0]         data_in,
    output logic                 pend_valid,
    output logic [D-1:0]         pend_addr,
    output logic [7:0]           drop_cnt,
    output logic [$clog2(N)-1:0] dbg_ptr
);

    localparam int PW = $clog2(N);

    if (N < 2 || N > 4) begin : g_bad_n
        $error("rf_wr_arbiter: N must be in 2..4");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] ptr_q,         ptr_d;
    logic          stage_valid_q, stage_valid_d;
    logic [D-1:0]  stage_addr_q,  stage_addr_d;
    logic [W-1:0]  stage_data_q,  stage_data_d;
    logic [7:0]    drop_cnt_q,    drop_cnt_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [N-1:0]  grant;
    logic          xfer;
    logic [PW-1:0] win_idx;
    logic [D-1:0]  win_addr;
    logic [W-1:0]  win_data;
    logic          win_lock;

    rr_pick #(
        .N (N)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // The grant is already qualified by req_valid, so any grant bit is a
    // transfer.
    assign req_ready = grant;
    assign xfer      = |grant;

    // Mux out the winner's index, address, data and lock from the one-hot
    // grant.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        win_lock = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_idx  = PW'(i);
                win_addr = req_addr[i*D +: D];
                win_data = req_data[i*W +: W];
                win_lock = req_lock[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_d         = ptr_q;
        stage_valid_d = xfer;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        drop_cnt_d    = drop_cnt_q;
        if (xfer) begin
            stage_addr_d = win_addr;
            stage_data_d = win_data;
            // A locked winner parks the pointer on itself so its next request
            // wins again; otherwise priority moves to the next requester.
            if (win_lock) begin
                ptr_d = win_idx;
            end else if (win_idx == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + PW'(1);
            end
            // Address 0 is accepted but discarded; count it here.
            if (win_addr == '0) begin
                drop_cnt_d = sat_inc8(drop_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            drop_cnt_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Write-stage outputs
    // -------------------------------------------------------------------------
    // Built from registers only, so an asynchronous reset kills a staged
    // write immediately.
    assign write_en   = stage_valid_q && (stage_addr_q != '0);
    assign waddr      = stage_addr_q;
    assign data_in    = stage_data_q;
    assign pend_valid = write_en;
    assign pend_addr  = stage_addr_q;
    assign drop_cnt   = drop_cnt_q;
    assign dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int N  = 2;
    localparam int PW = 1;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [N*D-1:0] req_addr;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic           write_en;
    logic [D-1:0]   waddr;
    logic [W-1:0]   data_in;
    logic           pend_valid;
    logic [D-1:0]   pend_addr;
    logic [7:0]     drop_cnt;
    logic [PW-1:0]  dbg_ptr;

    rf_wr_arbiter #(.W(W), .D(D), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .write_en   (write_en),
        .waddr      (waddr),
        .data_in    (data_in),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .drop_cnt   (drop_cnt),
        .dbg_ptr    (dbg_ptr)
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Register file fed by the DUT write port (used for the read-back check)
    // -------------------------------------------------------------------------
    logic [W-1:0] rf [8];
    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
    end
    always @(posedge clk) begin
        if (write_en) rf[waddr] <= data_in;
    end

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int                 m_ptr;
    logic               m_sv;
    logic [D-1:0]       m_sa;
    logic [W-1:0]       m_sd;
    int                 m_drop;
    logic [D+W-1:0]     exp_q[$];

    // Index of the requester that should win, or -1 when none is valid.
    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            t = v >> i;
            if (t[0]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  = 0;
            m_sv   = 1'b0;
            m_sa   = '0;
            m_sd   = '0;
            m_drop = 0;
            exp_q.delete();
        end else begin
            int           w;
            logic [D-1:0] a;
            logic [W-1:0] d;
            logic [N-1:0] lk;
            w = pick(req_valid, m_ptr);
            if (w >= 0) begin
                a    = D'(req_addr >> (w * D));
                d    = W'(req_data >> (w * W));
                lk   = req_lock >> w;
                m_sv = 1'b1;
                m_sa = a;
                m_sd = d;
                if (a == 0) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    exp_q.push_back({a, d});
                end
                m_ptr = lk[0] ? w : (w + 1) % N;
            end else begin
                m_sv = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare and write scoreboard
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [N-1:0]   er;
        logic [D+W-1:0] e;
        int             w;
        logic           ew;
        w  = pick(req_valid, m_ptr);
        er = (w >= 0) ? (N'(1) << w) : '0;
        ew = m_sv && (m_sa != 0);
        chk("cyc_ready",      32'(req_ready),  32'(er));
        chk("cyc_write_en",   32'(write_en),   32'(ew));
        chk("cyc_waddr",      32'(waddr),      32'(m_sa));
        chk("cyc_data_in",    32'(data_in),    32'(m_sd));
        chk("cyc_pend_valid", 32'(pend_valid), 32'(ew));
        chk("cyc_pend_addr",  32'(pend_addr),  32'(m_sa));
        chk("cyc_drop_cnt",   32'(drop_cnt),   32'(m_drop));
        chk("cyc_ptr",        32'(dbg_ptr),    32'(m_ptr));
        if (write_en) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_write", 32'({waddr, data_in}), 32'(e));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input bit v0, input int a0, input int d0, input bit l0,
                         input bit v1, input int a1, input int d1, input bit l1);
        req_valid = {v1, v0};
        req_addr  = {D'(a1), D'(a0)};
        req_data  = {W'(d1), W'(d0)};
        req_lock  = {l1, l0};
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // -------------------------------------------------------------------------
    logic [1:0] rr_rdy [4];
    int         rr_wa  [4];
    int         rr_wd  [4];
    logic [1:0] lk_rdy [5];

    initial begin
        rr_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_wa  = '{1, 2, 1, 2};
        rr_wd  = '{'hA1, 'hB2, 'hA1, 'hB2};
        lk_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_en",   32'(write_en),   0);
        chk("rst_waddr",      32'(waddr),      0);
        chk("rst_data_in",    32'(data_in),    0);
        chk("rst_pend_valid", 32'(pend_valid), 0);
        chk("rst_pend_addr",  32'(pend_addr),  0);
        chk("rst_drop_cnt",   32'(drop_cnt),   0);
        chk("rst_ptr",        32'(dbg_ptr),    0);
        rst_n = 1'b1;
        step();

        // Round-robin: both valid, no lock.
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(1, 1, 'hA1, 0, 1, 2, 'hB2, 0);
            else       idle();
            #1;
            if (c < 4) chk("rr_ready", 32'(req_ready), 32'(rr_rdy[c]));
            if (c > 0) begin
                chk("rr_waddr",   32'(waddr),   32'(rr_wa[c-1]));
                chk("rr_data_in", 32'(data_in), 32'(rr_wd[c-1]));
            end
            step();
        end

        // Lock burst: req0 locked for 3 grants, then unlocked, then req1.
        for (int c = 0; c < 6; c++) begin
            if (c < 3)      drive(1, 3, 'h11 + c, 1, 1, 4, 'h44, 0);
            else if (c < 5) drive(1, 3, 'h14, 0, 1, 4, 'h44, 0);
            else            idle();
            #1;
            if (c < 5) chk("lock_ready", 32'(req_ready), 32'(lk_rdy[c]));
            if (c > 0 && c < 4) chk("lock_ptr", 32'(dbg_ptr), 0);
            step();
        end

        // Address 0: accepted, never written, counted and saturated.
        drive(0, 0, 0, 0, 1, 0, 'hFF, 0);
        #1;
        chk("a0_ready", 32'(req_ready), 32'b10);
        step();
        idle();
        #1;
        chk("a0_write_en", 32'(write_en), 0);
        chk("a0_drop_1",   32'(drop_cnt), 1);
        for (int c = 0; c < 299; c++) begin
            drive(0, 0, 0, 0, 1, 0, 'hFF, 0);
            step();
        end
        idle();
        #1;
        chk("a0_drop_sat", 32'(drop_cnt), 255);
        chk("a0_write_en_sat", 32'(write_en), 0);
        step();

        // Latency / hazard: accept in T, pending in T+1, readable in T+2.
        drive(1, 5, 'h3C, 0, 0, 0, 0, 0);
        #1;
        chk("lat_ready", 32'(req_ready), 32'b01);
        step();
        idle();
        #1;
        chk("lat_pend_valid", 32'(pend_valid), 1);
        chk("lat_pend_addr",  32'(pend_addr),  5);
        chk("lat_write_en",   32'(write_en),   1);
        chk("lat_data_in",    32'(data_in),    'h3C);
        step();
        chk("lat_rf_read", 32'(rf[5]), 'h3C);

        // Idle with the pointer parked at 1.
        for (int c = 0; c < 10; c++) begin
            idle();
            #1;
            chk("idle_ready",    32'(req_ready), 0);
            chk("idle_write_en", 32'(write_en),  0);
            chk("idle_ptr",      32'(dbg_ptr),   1);
            step();
        end

        // Reset mid-burst with a staged write.
        drive(1, 6, 'h66, 0, 1, 3, 'h55, 0);
        #1;
        chk("mid_ready", 32'(req_ready), 32'b10);
        step();
        chk("mid_write_en", 32'(write_en), 1);
        chk("mid_waddr",    32'(waddr),    3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write_en",   32'(write_en),   0);
        chk("mid_rst_pend_valid", 32'(pend_valid), 0);
        chk("mid_rst_drop_cnt",   32'(drop_cnt),   0);
        chk("mid_rst_ready",      32'(req_ready),  32'b01);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b01);
        step();
        idle();
        #1;
        chk("post_rst_write_en", 32'(write_en), 1);
        chk("post_rst_waddr",    32'(waddr),    6);
        chk("post_rst_data_in",  32'(data_in),  'h66);
        repeat (3) step();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Round-robin arbiter that shares the register file's single write port (write_en/waddr/data_in) between N independent requesters. Each requester uses a valid/ready handshake. One winner is registered per cycle into a write stage that drives the register file. The block sits between the execution/load units and the register file. It also exposes the in-flight write address so read-side logic can detect a read-after-write hazard one cycle early.

## Interface
- W, 8, data width; matches register file W
- D, 3, address width; register file depth is 2**D
- N, 2, number of requesters; legal range 2..4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester write request
- req_addr  in  N×D  per-requester destination address
- req_data  in  N×W  per-requester write data
- req_lock  in  N  keep grant with this requester on its next request; burst without re-arbitration
- req_ready  out  N  one-hot or zero; accept strobe for the current cycle
- write_en  out  1  to register file
- waddr  out  D  to register file
- data_in  out  W  to register file
- pend_valid  out  1  a write is in the write stage this cycle (address nonzero)
- pend_addr  out  D  address of that write
- drop_cnt  out  8  saturating count of accepted writes to address 0

## Operation
- Arbitration is combinational within the cycle:
  - Search starts at priority pointer ptr and proceeds upward with wrap (ptr, ptr+1, … mod N).
  - The first requester with req_valid=1 gets req_ready=1.
  - At most one req_ready bit is high. req_ready never asserts without its req_valid.
- Transfer occurs when req_valid[i] && req_ready[i]. The register file always accepts, so there is no backpressure beyond arbitration.
- Pointer update on a transfer by requester i:
  - If req_lock[i]=1, ptr stays at i.
  - Otherwise ptr = (i+1) mod N.
- With no transfer, ptr is unchanged.
- Write stage registers the winner: stage_valid<=1, stage_addr<=req_addr[i], stage_data<=req_data[i]. With no transfer, stage_valid<=0.
- Write-stage outputs:
  - write_en = stage_valid && (stage_addr != 0).
  - waddr = stage_addr; data_in = stage_data.
  - pend_valid = write_en; pend_addr = stage_addr.
- Address 0 writes are accepted (req_ready asserts normally) but never drive write_en. Each one increments drop_cnt, which saturates at 255.
- Requesters must hold addr/data stable while valid && !ready. The arbiter does not check this.

## Timing
- Reset (rst_n low, asynchronous) clears the following:
  - ptr=0, stage_valid=0, stage_addr=0, stage_data=0, drop_cnt=0.
  - Therefore write_en=0, waddr=0, data_in=0, pend_valid=0, pend_addr=0.
  - req_ready is combinational from req_valid and ptr, so it follows ptr=0 immediately.
- Latency: accept in cycle T → write_en high in cycle T+1 → register file updated at the end of T+1. A read in T+2 sees the new value.
- Throughput: one write per cycle sustained; back-to-back from the same requester is allowed.
- Simultaneous requests: exactly one is granted per cycle. The others see ready=0 and retry.
- Lock with no follow-up request: ptr is parked at i. The next winner is found by the normal search from i, so there is no deadlock.
- Reset mid-operation:
  - A staged write is discarded (write_en drops immediately with rst_n, asynchronously).
  - Requesters must re-present any request that was not accepted.

## Structure
- Package rf_pkg: typedefs addr_t (logic [D-1:0]) and data_t (logic [W-1:0]); constant DROP_CNT_MAX=8'hFF.
- Sub-module rr_pick: combinational, N-bit valid + ptr → one-hot grant. Instanced once. Keeps the wrap-around search separately testable.
- The top holds the ptr register, write stage and drop counter.

## Test plan
- Reset: assert rst_n=0 mid-burst with stage_valid=1 → write_en=0, drop_cnt=0, pend_valid=0 immediately. After release, the first grant goes to requester 0 if both are valid.
- Round-robin: N=2, both valid for 4 cycles with lock=0, addrs 1/2, data 8'hA1/8'hB2 → grants 0,1,0,1. waddr sequence 1,2,1,2 one cycle later.
- Lock burst: req0 valid with lock=1 for 3 cycles, req1 valid throughout → req0 granted 3 times, then req1 granted the cycle after req0 drops lock.
- Address 0: req1 writes addr 0 data 8'hFF → req_ready=1, write_en stays 0, drop_cnt increments 0→1. After 300 such writes, drop_cnt=255.
- Latency/hazard: accept addr 5 data 8'h3C in cycle T → pend_valid=1, pend_addr=5 in T+1, and a register file read of address 5 returns 8'h3C in T+2.
- Idle: no valid for 10 cycles → req_ready=0, write_en=0, ptr unchanged.
